// File: rtl/mem_load_pkg.sv
// Shared types and constants for the memory load-and-run controller.
package mem_load_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoadI,
        StLoadD,
        StRun,
        StDone
    } state_e;

    // Byte stride between consecutive words of each memory.
    localparam int unsigned IMEM_STRIDE = 4;
    localparam int unsigned DMEM_STRIDE = 8;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mem_load_ctrl_if.sv
// Stream input and instruction/data memory write ports of mem_load_ctrl.
interface mem_load_ctrl_if;

    logic        in_valid;
    logic [63:0] in_data;
    logic        in_ready;

    logic [63:0] imem_addr;
    logic        imem_wen;
    logic [31:0] imem_wdata;

    logic [63:0] dmem_addr;
    logic        dmem_wen;
    logic [63:0] dmem_wdata;

    modport master (
        input  in_valid, in_data,
        output in_ready,
        output imem_addr, imem_wen, imem_wdata,
        output dmem_addr, dmem_wen, dmem_wdata
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready,
        input  imem_addr, imem_wen, imem_wdata,
        input  dmem_addr, dmem_wen, dmem_wdata
    );

endinterface

// File: rtl/load_counter.sv
// Up-counter with synchronous clear (priority over enable) and terminal-count compare.
module load_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             at_limit
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count    = count_q;
    assign at_limit = (count_q == limit);

endmodule

// File: rtl/mem_load_ctrl.sv
// Streams instruction then data words into memory, then enables the CPU for a fixed time.
// Optional MEM_LOAD_CHECKSUM_EN adds a running XOR checksum output of the streamed words.
module mem_load_ctrl
    import mem_load_pkg::*;
#(
    parameter int unsigned IMEM_WORDS = 128,
    parameter int unsigned DMEM_WORDS = 128,
    parameter int unsigned RUN_CYCLES = 1024
) (
    input  logic            clk,
    input  logic            arst_n,
    input  logic            start,
    input  logic            abort,
    mem_load_ctrl_if.master bus,
    output logic            cpu_enable,
    output logic            busy,
    output logic            done
`ifdef MEM_LOAD_CHECKSUM_EN
    ,
    output logic [63:0]     checksum
`endif
);

    localparam int unsigned MAX_WORDS = max_u(IMEM_WORDS, DMEM_WORDS);
    localparam int unsigned WORD_W    = $clog2(MAX_WORDS + 1);
    localparam int unsigned RUN_W     = $clog2(RUN_CYCLES + 1);

    state_e state_q, state_d;

    logic              xfer;
    logic              word_last;
    logic              run_last;
    logic [WORD_W-1:0] word_idx;
    logic [WORD_W-1:0] word_limit;
    logic [RUN_W-1:0]  unused_run_cnt;

    assign bus.in_ready = (state_q == StLoadI) || (state_q == StLoadD);
    assign xfer         = bus.in_valid && bus.in_ready;
    assign word_limit   = (state_q == StLoadI) ? WORD_W'(IMEM_WORDS - 1) : WORD_W'(DMEM_WORDS - 1);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone: if (start) state_d = StLoadI;
            StLoadI:        if (xfer && word_last) state_d = StLoadD;
            StLoadD:        if (xfer && word_last) state_d = StRun;
            StRun:          if (run_last) state_d = StDone;
            default:        state_d = StIdle;
        endcase
        if (abort) state_d = StIdle;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Every state change starts the word index from zero.
    load_counter #(
        .WIDTH (WORD_W)
    ) u_word_cnt (
        .clk      (clk),
        .arst_n   (arst_n),
        .clr      (state_d != state_q),
        .en       (xfer),
        .limit    (word_limit),
        .count    (word_idx),
        .at_limit (word_last)
    );

    load_counter #(
        .WIDTH (RUN_W)
    ) u_run_cnt (
        .clk      (clk),
        .arst_n   (arst_n),
        .clr      (state_q != StRun),
        .en       (1'b1),
        .limit    (RUN_W'(RUN_CYCLES - 1)),
        .count    (unused_run_cnt),
        .at_limit (run_last)
    );

    // Write ports are registered: a transfer shows up as a strobe on the next cycle.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            bus.imem_wen   <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_wdata <= '0;
            bus.dmem_wen   <= 1'b0;
            bus.dmem_addr  <= '0;
            bus.dmem_wdata <= '0;
        end else begin
            bus.imem_wen <= xfer && (state_q == StLoadI);
            bus.dmem_wen <= xfer && (state_q == StLoadD);
            if (xfer && (state_q == StLoadI)) begin
                bus.imem_addr  <= 64'(word_idx) * 64'(IMEM_STRIDE);
                bus.imem_wdata <= bus.in_data[31:0];
            end
            if (xfer && (state_q == StLoadD)) begin
                bus.dmem_addr  <= 64'(word_idx) * 64'(DMEM_STRIDE);
                bus.dmem_wdata <= bus.in_data;
            end
        end
    end

    assign cpu_enable = (state_q == StRun);
    assign busy       = (state_q == StLoadI) || (state_q == StLoadD) || (state_q == StRun);
    assign done       = (state_q == StDone);

`ifdef MEM_LOAD_CHECKSUM_EN
    logic        start_accept;
    logic [63:0] checksum_q;

    assign start_accept = start && !abort && ((state_q == StIdle) || (state_q == StDone));

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            checksum_q <= '0;
        end else if (start_accept) begin
            checksum_q <= '0;
        end else if (xfer) begin
            checksum_q <= checksum_q ^ bus.in_data;
        end
    end

    assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_mem_load_ctrl.sv
// Self-checking bench for mem_load_ctrl: random stream words against an address/data model.
module tb_mem_load_ctrl;

    localparam int unsigned IW = 4;
    localparam int unsigned DW = 2;
    localparam int unsigned RC = 5;
    localparam int unsigned NW = IW + DW;

    logic clk = 1'b0;
    logic arst_n;
    logic start;
    logic abort;
    logic cpu_enable;
    logic busy;
    logic done;
`ifdef MEM_LOAD_CHECKSUM_EN
    logic [63:0] checksum;
`endif

    mem_load_ctrl_if bus ();

    mem_load_ctrl #(
        .IMEM_WORDS (IW),
        .DMEM_WORDS (DW),
        .RUN_CYCLES (RC)
    ) dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .start      (start),
        .abort      (abort),
        .bus        (bus),
        .cpu_enable (cpu_enable),
        .busy       (busy),
        .done       (done)
`ifdef MEM_LOAD_CHECKSUM_EN
        ,
        .checksum   (checksum)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [63:0] wq [NW];
    logic [63:0] ia [$];
    logic [63:0] id [$];
    logic [63:0] da [$];
    logic [63:0] dd [$];

    // Write log: every strobe seen between clock edges
    always @(negedge clk) begin
        if (bus.imem_wen === 1'b1) begin
            ia.push_back(bus.imem_addr);
            id.push_back(64'(bus.imem_wdata));
        end
        if (bus.dmem_wen === 1'b1) begin
            da.push_back(bus.dmem_addr);
            dd.push_back(bus.dmem_wdata);
        end
    end

    task automatic clear_logs();
        ia.delete(); id.delete(); da.delete(); dd.delete();
    endtask

    task automatic fill_random();
        for (int i = 0; i < NW; i++) wq[i] = {$urandom, $urandom};
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Present words first..last_excl-1; optional stall of stall_len cycles before word stall_at.
    task automatic stream(input int first, input int last_excl, input int stall_at,
                          input int stall_len);
        int budget;
        for (int i = first; i < last_excl; i++) begin
            if (i == stall_at) begin
                bus.in_valid = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    @(negedge clk);
                    total++;
                    if (bus.imem_wen !== 1'b0 || bus.dmem_wen !== 1'b0) begin
                        bad++;
                        $display("FAIL stall_strobe cycle %0d: imem_wen=%b dmem_wen=%b, want 0 0",
                                 s, bus.imem_wen, bus.dmem_wen);
                    end
                end
            end
            bus.in_data  = wq[i];
            bus.in_valid = 1'b1;
            budget = 0;
            while (bus.in_ready !== 1'b1 && budget < 20) begin
                @(negedge clk);
                budget++;
            end
            if (bus.in_ready !== 1'b1) begin
                total++; bad++;
                $display("FAIL ready_timeout word %0d: in_ready=%b, want 1", i, bus.in_ready);
                bus.in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        arst_n = 1'b0; start = 1'b0; abort = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0;
        #1;
        total++;
        if ({bus.in_ready, bus.imem_wen, bus.dmem_wen, cpu_enable, busy, done} !== 6'b0 ||
            bus.imem_addr !== 64'd0 || bus.imem_wdata !== 32'd0 ||
            bus.dmem_addr !== 64'd0 || bus.dmem_wdata !== 64'd0) begin
            bad++;
            $display("FAIL reset_outputs: rdy=%b iwen=%b dwen=%b en=%b busy=%b done=%b, want all 0",
                     bus.in_ready, bus.imem_wen, bus.dmem_wen, cpu_enable, busy, done);
        end
`ifdef MEM_LOAD_CHECKSUM_EN
        total++;
        if (checksum !== 64'd0) begin
            bad++;
            $display("FAIL reset_checksum: got %h, want 0", checksum);
        end
`endif
        @(negedge clk); @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || bus.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: busy=%b done=%b rdy=%b, want 0 0 0", busy, done, bus.in_ready);
        end
    endtask

    task automatic test_load_run(input int stall_at, input int stall_len);
        int n_run;
        logic [63:0] exp_cs;
        fill_random();
        exp_cs = '0;
        for (int i = 0; i < NW; i++) exp_cs ^= wq[i];
        clear_logs();
        pulse_start();
        total++;
        if (busy !== 1'b1 || bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL start_busy: busy=%b rdy=%b, want 1 1", busy, bus.in_ready);
        end
        stream(0, NW, stall_at, stall_len);
        total++;
        if (cpu_enable !== 1'b1 || bus.dmem_wen !== 1'b1) begin
            bad++;
            $display("FAIL first_run_cycle: cpu_enable=%b dmem_wen=%b, want 1 1",
                     cpu_enable, bus.dmem_wen);
        end
        n_run = 1;
        for (int b = 0; b < 40; b++) begin
            @(negedge clk);
            if (done === 1'b1) break;
            if (cpu_enable === 1'b1) n_run++;
        end
        total++;
        if (n_run != RC || done !== 1'b1 || busy !== 1'b0 || cpu_enable !== 1'b0) begin
            bad++;
            $display("FAIL run_length: run=%0d done=%b busy=%b en=%b, want %0d 1 0 0",
                     n_run, done, busy, cpu_enable, RC);
        end
        total++;
        if (ia.size() != IW || da.size() != DW) begin
            bad++;
            $display("FAIL write_count: imem=%0d dmem=%0d, want %0d %0d",
                     ia.size(), da.size(), IW, DW);
        end
        for (int k = 0; k < IW && k < ia.size(); k++) begin
            total++;
            if (ia[k] !== 64'(4 * k) || id[k] !== 64'(wq[k][31:0])) begin
                bad++;
                $display("FAIL imem_write %0d: addr=%0h data=%h, want %0h %h",
                         k, ia[k], id[k], 4 * k, wq[k][31:0]);
            end
        end
        for (int k = 0; k < DW && k < da.size(); k++) begin
            total++;
            if (da[k] !== 64'(8 * k) || dd[k] !== wq[IW + k]) begin
                bad++;
                $display("FAIL dmem_write %0d: addr=%0h data=%h, want %0h %h",
                         k, da[k], dd[k], 8 * k, wq[IW + k]);
            end
        end
        total++;
        if (bus.imem_addr !== 64'(4 * (IW - 1)) || bus.imem_wdata !== wq[IW - 1][31:0] ||
            bus.dmem_addr !== 64'(8 * (DW - 1)) || bus.dmem_wdata !== wq[NW - 1]) begin
            bad++;
            $display("FAIL hold_regs: iaddr=%0h daddr=%0h, want %0h %0h",
                     bus.imem_addr, bus.dmem_addr, 4 * (IW - 1), 8 * (DW - 1));
        end
`ifdef MEM_LOAD_CHECKSUM_EN
        total++;
        if (checksum !== exp_cs) begin
            bad++;
            $display("FAIL checksum_random: got %h, want %h", checksum, exp_cs);
        end
`endif
        @(negedge clk);
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL done_hold: done=%b, want 1", done);
        end
    endtask

    task automatic test_abort_run();
        fill_random();
        pulse_start();
        stream(0, NW, -1, 0);
        @(negedge clk);
        total++;
        if (cpu_enable !== 1'b1) begin
            bad++;
            $display("FAIL second_run_cycle: cpu_enable=%b, want 1", cpu_enable);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        total++;
        if (cpu_enable !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || bus.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL abort_idle: en=%b busy=%b done=%b rdy=%b, want 0 0 0 0",
                     cpu_enable, busy, done, bus.in_ready);
        end
        @(negedge clk);
        clear_logs();
        pulse_start();
        stream(0, 1, -1, 0);
        @(negedge clk);
        total++;
        if (ia.size() != 1 || ia[0] !== 64'd0 || id[0] !== 64'(wq[0][31:0])) begin
            bad++;
            $display("FAIL restart_addr: writes=%0d, want 1 at addr 0", ia.size());
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_load: busy=%b, want 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        fill_random();
        pulse_start();
        stream(0, IW + 1, -1, 0);
        #2 arst_n = 1'b0;
        #1;
        total++;
        if ({bus.in_ready, bus.imem_wen, bus.dmem_wen, cpu_enable, busy, done} !== 6'b0 ||
            bus.imem_addr !== 64'd0 || bus.dmem_addr !== 64'd0 ||
            bus.imem_wdata !== 32'd0 || bus.dmem_wdata !== 64'd0) begin
            bad++;
            $display("FAIL async_reset: rdy=%b dwen=%b busy=%b daddr=%0h, want 0 0 0 0",
                     bus.in_ready, bus.dmem_wen, busy, bus.dmem_addr);
        end
`ifdef MEM_LOAD_CHECKSUM_EN
        total++;
        if (checksum !== 64'd0) begin
            bad++;
            $display("FAIL async_reset_checksum: got %h, want 0", checksum);
        end
`endif
        clear_logs();
        @(negedge clk); @(negedge clk);
        #2 arst_n = 1'b1;
        for (int i = 0; i < 4; i++) @(negedge clk);
        total++;
        if (da.size() != 0 || ia.size() != 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_writes: dmem=%0d imem=%0d busy=%b, want 0 0 0",
                     da.size(), ia.size(), busy);
        end
    endtask

    task automatic test_start_abort();
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || bus.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL start_abort_idle: busy=%b done=%b rdy=%b, want 0 0 0",
                     busy, done, bus.in_ready);
        end
        fill_random();
        clear_logs();
        pulse_start();
        stream(0, 2, -1, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stream(2, NW, -1, 0);
        for (int b = 0; b < 40 && done !== 1'b1; b++) @(negedge clk);
        total++;
        if (done !== 1'b1 || ia.size() != IW || da.size() != DW) begin
            bad++;
            $display("FAIL start_in_load: done=%b imem=%0d dmem=%0d, want 1 %0d %0d",
                     done, ia.size(), da.size(), IW, DW);
        end
        for (int k = 0; k < IW && k < ia.size(); k++) begin
            total++;
            if (ia[k] !== 64'(4 * k)) begin
                bad++;
                $display("FAIL start_in_load_addr %0d: got %0h, want %0h", k, ia[k], 4 * k);
            end
        end
    endtask

`ifdef MEM_LOAD_CHECKSUM_EN
    task automatic test_checksum();
        wq[0] = 64'h1;  wq[1] = 64'h2;  wq[2] = 64'h4;
        wq[3] = 64'h8;  wq[4] = 64'hF0; wq[5] = 64'hF00;
        pulse_start();
        stream(0, NW, -1, 0);
        for (int b = 0; b < 40 && done !== 1'b1; b++) @(negedge clk);
        @(negedge clk);
        total++;
        if (done !== 1'b1 || checksum !== 64'hFFF) begin
            bad++;
            $display("FAIL checksum_fixed: done=%b checksum=%h, want 1 fff", done, checksum);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_load_run(-1, 0);
        test_load_run(2, 3);
        test_abort_run();
        test_reset_mid();
        test_start_abort();
`ifdef MEM_LOAD_CHECKSUM_EN
        test_checksum();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_load_ctrl.md
MEM_LOAD_CTRL -- requirements
Module: mem_load_ctrl

Interface
REQ-001 Parameter IMEM_WORDS, default 128: number of 32-bit instruction words to load; legal range 1..512.
REQ-002 Parameter DMEM_WORDS, default 128: number of 64-bit data words to load; legal range 1..1024.
REQ-003 Parameter RUN_CYCLES, default 1024: number of cycles the CPU is enabled after loading; must be at least 1.
REQ-004 Clock is `clk`, input, 1 bit; the block uses this single clock only.
REQ-005 Reset is `arst_n`, input, 1 bit, asynchronous and active-low.
REQ-006 `start`, input, 1 bit: pulse that begins a load-and-run sequence.
REQ-007 `abort`, input, 1 bit: terminates any sequence in progress.
REQ-008 `in_valid`, input, 1 bit: the source has a word on `in_data`.
REQ-009 `in_data`, input, 64 bits: stream word.
REQ-010 `in_ready`, output, 1 bit: the block accepts the current word.
REQ-011 `imem_addr`, output, 64 bits; `imem_wen`, output, 1 bit; `imem_wdata`, output, 32 bits: instruction-memory external write port.
REQ-012 `dmem_addr`, output, 64 bits; `dmem_wen`, output, 1 bit; `dmem_wdata`, output, 64 bits: data-memory external write port.
REQ-013 `cpu_enable`, output, 1 bit: drives the CPU run enable.
REQ-014 `busy`, output, 1 bit, and `done`, output, 1 bit: status.

Function
REQ-015 The FSM states SHALL be IDLE, LOAD_I, LOAD_D, RUN and DONE.
REQ-016 In IDLE or DONE, `start`=1 SHALL move the FSM to LOAD_I and clear the word counter.
REQ-017 A transfer SHALL occur on any cycle with `in_valid` & `in_ready`.
  - `in_ready` = 1 only in LOAD_I and LOAD_D.
REQ-018 A transfer in LOAD_I with index k SHALL write on the following cycle:
  - `imem_wen` = 1
  - `imem_addr` = 4*k
  - `imem_wdata` = `in_data[31:0]` (bits 63:32 ignored)
REQ-019 A transfer in LOAD_D with index k SHALL write on the following cycle:
  - `dmem_wen` = 1
  - `dmem_addr` = 8*k
  - `dmem_wdata` = `in_data`
REQ-020 Write strobes SHALL be single-cycle pulses.
  - Address and data registers hold their last value while no write is in progress.
REQ-021 The IMEM_WORDS-th transfer in LOAD_I SHALL move the FSM to LOAD_D and clear the counter in the same cycle.
REQ-022 The DMEM_WORDS-th transfer in LOAD_D SHALL move the FSM to RUN.
REQ-023 `cpu_enable` SHALL be 1 exactly during RUN.
  - RUN lasts RUN_CYCLES cycles, counted from the first RUN cycle.
  - The FSM then moves to DONE.
  - RUN is entered one cycle after the last transfer, so the last data write (REQ-019) completes on the first RUN cycle.
REQ-024 `busy` SHALL be 1 in LOAD_I, LOAD_D and RUN; `done` SHALL be 1 only in DONE.
REQ-025 `start` while `busy`=1 SHALL be ignored.
REQ-026 `abort`=1 in any state SHALL force IDLE on the next edge and deassert `in_ready`, `cpu_enable` and `busy`.
  - A write strobe already scheduled from a transfer in the previous cycle still completes.
REQ-027 If `abort` and `start` are both 1 in the same cycle, `abort` SHALL take priority.
REQ-028 Stalls are allowed: `in_valid`=0 during a load SHALL hold the state and the counter indefinitely.
REQ-029 Counters SHALL be sized to hold the maximum parameter value and SHALL never wrap in legal use.

Reset
REQ-030 While `arst_n`=0, the block SHALL be in IDLE with all counters 0 and all outputs 0.
  - Reset takes effect immediately, without a clock edge.
REQ-031 Reset asserted mid-sequence SHALL abandon the sequence; no write strobe is issued after release until a new transfer occurs.

Configuration
REQ-032 With `MEM_LOAD_CHECKSUM_EN` defined, the block SHALL add a 64-bit output `checksum`.
  - `checksum` is the running XOR of all 64-bit `in_data` words transferred in the current sequence.
  - It is cleared on `start` acceptance and on reset, and holds its value in DONE.
REQ-033 Without `MEM_LOAD_CHECKSUM_EN`, the `checksum` port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-034 The state encoding enum and the address stride constants (4 and 8) SHALL reside in the shared package `mem_load_pkg`.
REQ-035 The block SHALL use one sub-module, `load_counter`: an up-counter with clear, enable and a terminal-count compare.
  - It is instantiated twice: once for the word index and once for the run cycles.

Verification
REQ-036 IMEM_WORDS=4, DMEM_WORDS=2, RUN_CYCLES=5; pulse `start`, then stream 6 words with `in_valid` held at 1.
  - Expect imem writes at addresses 0, 4, 8, 12.
  - Expect dmem writes at addresses 0, 8.
  - Expect `cpu_enable` high for exactly 5 cycles, then `done`=1.
REQ-037 Deassert `in_valid` for 3 cycles after word 2.
  - Expect no strobes during the stall.
  - Expect addresses to continue at 8 with no skip or repeat.
REQ-038 Assert `abort` in the second RUN cycle.
  - Expect `cpu_enable`=0 and `busy`=0 on the next cycle, state IDLE.
  - Expect a following `start` to restart the sequence at imem address 0.
REQ-039 Assert `arst_n`=0 asynchronously mid-LOAD_D.
  - Expect all outputs 0 immediately.
  - Expect no `dmem_wen` after release.
REQ-040 Drive `start` and `abort` together in IDLE, and `start` during LOAD_I.
  - Expect the FSM to stay in IDLE in the first case.
  - Expect the counter unaffected in the second case.
REQ-041 With `MEM_LOAD_CHECKSUM_EN` defined, stream the words 0x1, 0x2, 0x4, 0x8, 0xF0, 0xF00.
  - Expect `checksum` = 0xFFF in DONE.
